// File: rtl/memory_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// memory_bus_arbiter_pkg
// Shared MemoryBus types used by the arbiter, its interface and its sub-blocks:
//   BusPacketType / BusID / memory_address_t / bus_packet_payload_t / BusPacket,
//   the create_bus_packet() constructor, and the arbiter FSM state encoding.
// -----------------------------------------------------------------------------
package memory_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        bus_read_data      = 2'd0,
        bus_write_data     = 2'd1,
        bus_read_response  = 2'd2,
        bus_write_response = 2'd3
    } BusPacketType;

    typedef logic [3:0]  BusID;
    typedef logic [31:0] memory_address_t;
    typedef logic [31:0] bus_packet_payload_t;

    typedef struct packed {
        BusPacketType        pkt_type;
        BusID                id;
        memory_address_t     addr;
        bus_packet_payload_t payload;
    } BusPacket;

    // FSM encoding kept as plain constants for compatibility with older flows.
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ARB_IDLE     = 2'd0;
    localparam arb_state_t ARB_ISSUE    = 2'd1;
    localparam arb_state_t ARB_WAIT_RSP = 2'd2;

    function automatic BusPacket create_bus_packet(
        input BusPacketType        pkt_type,
        input BusID                id,
        input memory_address_t     addr,
        input bus_packet_payload_t payload
    );
        BusPacket p;
        p.pkt_type = pkt_type;
        p.id       = id;
        p.addr     = addr;
        p.payload  = payload;
        return p;
    endfunction

endpackage

// File: rtl/memory_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// memory_bus_arbiter_if
// Bundles the master-side request/response channels and the memory-side
// MemoryBus channel of the arbiter.
//   modport master : arbiter view (drives grants, bus request, routed response)
//   modport slave  : environment view (masters + memory endpoint)
// -----------------------------------------------------------------------------
interface memory_bus_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import memory_bus_arbiter_pkg::*;

    logic     [NUM_REQ-1:0] m_req_valid;
    BusPacket [NUM_REQ-1:0] m_req_pkt;
    logic     [NUM_REQ-1:0] m_req_ready;
    logic     [NUM_REQ-1:0] m_rsp_valid;
    BusPacket               m_rsp_pkt;
    logic     [NUM_REQ-1:0] m_rsp_ready;
    logic                   bus_req_valid;
    BusPacket               bus_req_pkt;
    logic                   bus_req_ready;
    logic                   bus_rsp_valid;
    BusPacket               bus_rsp_pkt;
    logic                   bus_rsp_ready;
    logic                   bus_timeout;

    modport master (
        input  m_req_valid, m_req_pkt, m_rsp_ready,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_pkt,
        output m_req_ready, m_rsp_valid, m_rsp_pkt,
        output bus_req_valid, bus_req_pkt, bus_rsp_ready, bus_timeout
    );

    modport slave (
        output m_req_valid, m_req_pkt, m_rsp_ready,
        output bus_req_ready, bus_rsp_valid, bus_rsp_pkt,
        input  m_req_ready, m_rsp_valid, m_rsp_pkt,
        input  bus_req_valid, bus_req_pkt, bus_rsp_ready, bus_timeout
    );

endinterface

// File: rtl/memory_bus_arbiter_chk.sv
// -----------------------------------------------------------------------------
// memory_bus_arbiter_chk
// Protocol checks for the arbiter: only read/write requests may be issued to
// memory, and memory must not present a response unless a read is waiting.
//   Ports: clk, rstn, state_q, req_type, bus_req_ready, bus_rsp_valid.
// -----------------------------------------------------------------------------
module memory_bus_arbiter_chk
    import memory_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic         clk,
    input logic         rstn,
    input arb_state_t   state_q,
    input BusPacketType req_type,
    input logic         bus_req_ready,
    input logic         bus_rsp_valid
);

    a_cfg_timeout: assert property (@(posedge clk) TIMEOUT_CYCLES >= 1);

    a_req_type_legal: assert property (@(posedge clk) disable iff (!rstn)
        (state_q == ARB_ISSUE && bus_req_ready) |->
            (req_type == bus_read_data || req_type == bus_write_data));

    a_rsp_expected: assert property (@(posedge clk) disable iff (!rstn)
        bus_rsp_valid |-> (state_q == ARB_WAIT_RSP));

endmodule

// File: rtl/memory_bus_arbiter_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Round-robin priority selector: scans req starting at rr_ptr (wrapping at
// NUM_REQ) and reports the first set bit.
//   req    : request vector
//   rr_ptr : index with highest priority this cycle
//   grant  : one-hot winner (0 when no request)
//   idx    : winner index
//   any    : at least one request present
// -----------------------------------------------------------------------------
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);
    localparam int CW = IDX_W + 1;

    logic [CW-1:0] cand_s;

    // Rotating scan; the extra candidate bit makes the modulo wrap exact for any NUM_REQ.
    always_comb begin
        grant  = '0;
        idx    = '0;
        any    = 1'b0;
        cand_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = {1'b0, rr_ptr} + CW'(k);
            if (cand_s >= CW'(NUM_REQ)) begin
                cand_s = cand_s - CW'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!any && req[cand_s[IDX_W-1:0]]) begin
                any = 1'b1;
                idx = cand_s[IDX_W-1:0];
            end else begin
                any = any;
            end
        end
        if (any) begin
            grant = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
        end else begin
            grant = '0;
        end
    end

endmodule

// File: rtl/memory_bus_arbiter.sv
// -----------------------------------------------------------------------------
// memory_bus_arbiter
// Shares one MemoryBus request channel among NUM_REQ masters by round-robin,
// runs one transaction at a time and routes read responses to the owner.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : memory_bus_arbiter_if.master (master req/rsp + memory channel)
// Optional macro ARB_TIMEOUT_EN adds a read-response watchdog that pulses
// bus_timeout and abandons the read after TIMEOUT_CYCLES cycles in WAIT_RSP;
// without it bus_timeout is tied low and a read waits indefinitely.
// -----------------------------------------------------------------------------
module memory_bus_arbiter
    import memory_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int IDX_W          = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                clk,
    input logic                rstn,
    memory_bus_arbiter_if.master bus
);

    arb_state_t         state_q, state_d;
    BusPacket           pkt_q, pkt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] pick_grant_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               pick_any_s;
    logic               in_wait_s;
    logic               rsp_fire_s;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
`endif

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req    (bus.m_req_valid),
        .rr_ptr (rr_ptr_q),
        .grant  (pick_grant_s),
        .idx    (pick_idx_s),
        .any    (pick_any_s)
    );

    assign in_wait_s  = (state_q == ARB_WAIT_RSP);
    assign rsp_fire_s = in_wait_s && bus.bus_rsp_valid && bus.m_rsp_ready[owner_q];

    // Next-state, packet latch, owner and round-robin pointer update.
    always_comb begin
        state_d  = state_q;
        pkt_d    = pkt_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_any_s) begin
                    pkt_d    = bus.m_req_pkt[pick_idx_s];
                    owner_d  = pick_idx_s;
                    rr_ptr_d = (pick_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx_s + IDX_W'(1);
                    state_d  = ARB_ISSUE;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_ISSUE: begin
                // Anything other than a read is completed like a write.
                if (bus.bus_req_ready) begin
                    if (pkt_q.pkt_type == bus_read_data) begin
                        state_d = ARB_WAIT_RSP;
`ifdef ARB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else begin
                    state_d = ARB_ISSUE;
                end
            end
            ARB_WAIT_RSP: begin
                if (rsp_fire_s) begin
                    state_d = ARB_IDLE;
                end else begin
`ifdef ARB_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d   = ARB_IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`else
                    state_d = ARB_WAIT_RSP;
`endif
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ARB_IDLE;
            pkt_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pkt_q    <= pkt_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Grant is combinational on state+valid; masked while reset is asserted.
    assign bus.m_req_ready   = (rstn && state_q == ARB_IDLE) ? pick_grant_s : '0;
    assign bus.bus_req_valid = (state_q == ARB_ISSUE);
    assign bus.bus_req_pkt   = pkt_q;
    // Response path is a zero-latency pass-through to the owning master.
    assign bus.bus_rsp_ready = in_wait_s && bus.m_rsp_ready[owner_q];
    assign bus.m_rsp_valid   = (in_wait_s && bus.bus_rsp_valid) ?
                               ({{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q) : '0;
    assign bus.m_rsp_pkt     = in_wait_s ? bus.bus_rsp_pkt : '0;
`ifdef ARB_TIMEOUT_EN
    assign bus.bus_timeout   = timeout_q;
`else
    assign bus.bus_timeout   = 1'b0;
`endif

    memory_bus_arbiter_chk #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_chk (
        .clk           (clk),
        .rstn          (rstn),
        .state_q       (state_q),
        .req_type      (pkt_q.pkt_type),
        .bus_req_ready (bus.bus_req_ready),
        .bus_rsp_valid (bus.bus_rsp_valid)
    );

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_bus_arbiter
// Directed self-checking bench for memory_bus_arbiter (NUM_REQ = 4).
// Inputs change 1 time unit after the rising edge; outputs are compared
// between edges.
// -----------------------------------------------------------------------------
module tb_memory_bus_arbiter;
    import memory_bus_arbiter_pkg::*;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    memory_bus_arbiter_if #(.NUM_REQ(4)) bus_if ();

    memory_bus_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    BusPacket exp_pkt;
    BusPacket fair_pkt [4];
    int       waited;

    initial begin
        checks = 0;
        errors = 0;
        rstn   = 1'b0;
        bus_if.m_req_valid   = 4'b0000;
        bus_if.m_req_pkt     = '0;
        bus_if.m_rsp_ready   = 4'b0000;
        bus_if.bus_req_ready = 1'b0;
        bus_if.bus_rsp_valid = 1'b0;
        bus_if.bus_rsp_pkt   = '0;
        step();
        step();

        // Reset state
        chk("rst_m_req_ready",  128'(bus_if.m_req_ready),   128'(4'b0000));
        chk("rst_bus_req_valid", 128'(bus_if.bus_req_valid), 128'(1'b0));
        chk("rst_bus_req_pkt",  128'(bus_if.bus_req_pkt),   128'(0));
        chk("rst_bus_rsp_ready", 128'(bus_if.bus_rsp_ready), 128'(1'b0));
        chk("rst_m_rsp_valid",  128'(bus_if.m_rsp_valid),   128'(4'b0000));
        chk("rst_bus_timeout",  128'(bus_if.bus_timeout),   128'(1'b0));
        rstn = 1'b1;
        bus_if.bus_req_ready = 1'b1;
        step();

        // Single write from M0
        exp_pkt = create_bus_packet(bus_write_data, 4'd0, 32'h0000_0010, 32'h0000_00AB);
        bus_if.m_req_pkt[0] = exp_pkt;
        bus_if.m_req_valid  = 4'b0001;
        #1;
        chk("wr_grant", 128'(bus_if.m_req_ready), 128'(4'b0001));
        step();
        bus_if.m_req_valid = 4'b0000;
        #1;
        chk("wr_bus_valid", 128'(bus_if.bus_req_valid), 128'(1'b1));
        chk("wr_bus_pkt",   128'(bus_if.bus_req_pkt),   128'(exp_pkt));
        step();
        chk("wr_done_valid", 128'(bus_if.bus_req_valid), 128'(1'b0));
        bus_if.m_req_valid = 4'b0001;
        #1;
        chk("wr_idle_regrant", 128'(bus_if.m_req_ready), 128'(4'b0001));
        bus_if.m_req_valid = 4'b0000;
        #1;

        // Read from M2, response after 5 cycles routed only to M2
        exp_pkt = create_bus_packet(bus_read_data, 4'd2, 32'h0000_0040, 32'h0);
        bus_if.m_req_pkt[2] = exp_pkt;
        bus_if.m_req_valid  = 4'b0100;
        #1;
        chk("rd_grant", 128'(bus_if.m_req_ready), 128'(4'b0100));
        step();
        bus_if.m_req_valid = 4'b0000;
        #1;
        chk("rd_bus_valid", 128'(bus_if.bus_req_valid), 128'(1'b1));
        chk("rd_bus_pkt",   128'(bus_if.bus_req_pkt),   128'(exp_pkt));
        step();
        chk("rd_wait_valid", 128'(bus_if.bus_req_valid), 128'(1'b0));
        bus_if.m_rsp_ready = 4'b1011;
        #1;
        chk("rd_rsp_ready_other", 128'(bus_if.bus_rsp_ready), 128'(1'b0));
        bus_if.m_rsp_ready = 4'b0100;
        bus_if.m_req_valid = 4'b1111;
        #1;
        chk("rd_rsp_ready_owner", 128'(bus_if.bus_rsp_ready), 128'(1'b1));
        chk("rd_no_grant_wait",   128'(bus_if.m_req_ready),   128'(4'b0000));
        bus_if.m_req_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rd_no_rsp_yet", 128'(bus_if.m_rsp_valid), 128'(4'b0000));
        end
        step();
        exp_pkt = create_bus_packet(bus_read_response, 4'd2, 32'h0000_0040, 32'h0000_1234);
        bus_if.bus_rsp_pkt   = exp_pkt;
        bus_if.bus_rsp_valid = 1'b1;
        #1;
        chk("rd_rsp_valid",   128'(bus_if.m_rsp_valid),   128'(4'b0100));
        chk("rd_rsp_pkt",     128'(bus_if.m_rsp_pkt),     128'(exp_pkt));
        chk("rd_bus_rsp_rdy", 128'(bus_if.bus_rsp_ready), 128'(1'b1));
        step();
        bus_if.bus_rsp_valid = 1'b0;
        bus_if.m_rsp_ready   = 4'b0000;
        bus_if.m_req_valid   = 4'b0001;
        #1;
        chk("rd_done_rsp_valid", 128'(bus_if.m_rsp_valid), 128'(4'b0000));
        chk("rd_idle_grant",     128'(bus_if.m_req_ready), 128'(4'b0001));
        chk("rd_bus_timeout",    128'(bus_if.bus_timeout), 128'(1'b0));
        bus_if.m_req_valid = 4'b0000;
        #1;

        // Backpressure: rr_ptr = 3; M1 alone wins, then stalls 10 cycles
        bus_if.bus_req_ready = 1'b0;
        exp_pkt = create_bus_packet(bus_write_data, 4'd1, 32'h0000_0020, 32'h0000_0055);
        bus_if.m_req_pkt[1] = exp_pkt;
        bus_if.m_req_valid  = 4'b0010;
        #1;
        chk("bp_grant", 128'(bus_if.m_req_ready), 128'(4'b0010));
        step();
        bus_if.m_req_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid_held", 128'(bus_if.bus_req_valid), 128'(1'b1));
            chk("bp_pkt_stable", 128'(bus_if.bus_req_pkt),   128'(exp_pkt));
            chk("bp_no_grant",   128'(bus_if.m_req_ready),   128'(4'b0000));
            step();
        end
        bus_if.bus_req_ready = 1'b1;
        step();
        // rr_ptr is now 2
        chk("bp_next_grant", 128'(bus_if.m_req_ready), 128'(4'b0100));
        bus_if.m_req_valid = 4'b0000;
        #1;

        // Reset mid-read: M3 read in WAIT_RSP, then reset
        exp_pkt = create_bus_packet(bus_read_data, 4'd3, 32'h0000_0080, 32'h0);
        bus_if.m_req_pkt[3] = exp_pkt;
        bus_if.m_req_valid  = 4'b1000;
        #1;
        chk("rr_grant_m3", 128'(bus_if.m_req_ready), 128'(4'b1000));
        step();
        bus_if.m_req_valid = 4'b0000;
        step();
        bus_if.m_rsp_ready = 4'b1000;
        #1;
        chk("rr_wait_owner3", 128'(bus_if.bus_rsp_ready), 128'(1'b1));
        rstn = 1'b0;
        bus_if.m_req_valid = 4'b1111;
        #1;
        chk("rr_rst_rsp_ready", 128'(bus_if.bus_rsp_ready), 128'(1'b0));
        chk("rr_rst_req_valid", 128'(bus_if.bus_req_valid), 128'(1'b0));
        chk("rr_rst_req_pkt",   128'(bus_if.bus_req_pkt),   128'(0));
        chk("rr_rst_m_ready",   128'(bus_if.m_req_ready),   128'(4'b0000));
        chk("rr_rst_m_rsp",     128'(bus_if.m_rsp_valid),   128'(4'b0000));
        step();
        rstn = 1'b1;
        bus_if.m_rsp_ready = 4'b0000;
        #1;
        chk("rr_after_rst_m0", 128'(bus_if.m_req_ready), 128'(4'b0001));

        // Fairness: all four masters hold writes; grants go 0,1,2,3,0
        for (int i = 0; i < 4; i++) begin
            fair_pkt[i] = create_bus_packet(bus_write_data, 4'(i), 32'h0000_0100 + 32'(i), 32'(i));
            bus_if.m_req_pkt[i] = fair_pkt[i];
        end
        for (int n = 0; n < 5; n++) begin
            chk("fair_grant", 128'(bus_if.m_req_ready), 128'(4'b0001 << (n % 4)));
            step();
            chk("fair_bus_valid", 128'(bus_if.bus_req_valid), 128'(1'b1));
            chk("fair_bus_pkt",   128'(bus_if.bus_req_pkt),   128'(fair_pkt[n % 4]));
            chk("fair_no_grant",  128'(bus_if.m_req_ready),   128'(4'b0000));
            step();
        end
        bus_if.m_req_valid = 4'b0000;
        #1;

`ifdef ARB_TIMEOUT_EN
        // Watchdog: M1 read with no response; pulse 16 cycles after WAIT_RSP entry
        exp_pkt = create_bus_packet(bus_read_data, 4'd1, 32'h0000_0200, 32'h0);
        bus_if.m_req_pkt[1] = exp_pkt;
        bus_if.m_req_valid  = 4'b0010;
        #1;
        chk("to_grant", 128'(bus_if.m_req_ready), 128'(4'b0010));
        step();
        bus_if.m_req_valid = 4'b0000;
        step();
        bus_if.m_rsp_ready = 4'b0010;
        waited = 0;
        while (bus_if.bus_timeout !== 1'b1 && waited < 40) begin
            step();
            waited++;
        end
        chk("to_cycles",     128'(waited),               128'(16));
        chk("to_idle",       128'(bus_if.bus_rsp_ready), 128'(1'b0));
        chk("to_no_rsp",     128'(bus_if.m_rsp_valid),   128'(4'b0000));
        step();
        chk("to_pulse_end",  128'(bus_if.bus_timeout),   128'(1'b0));
        bus_if.m_rsp_ready = 4'b0000;
`else
        waited = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
